// File: rtl/reg_decoder_n.sv
// reg_decoder_n: registered one-hot decoder with optional auto-scan.
// Optional scan mode is compiled in with `define REG_DECODER_SCAN_EN.
//
// Parameters:
//   SEL_W    select width (1..6)
//   SCAN_DIV clock cycles per scan step (1..256)
//   OUT_W    2**SEL_W, derived, not overridable
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        block enable; low returns to IDLE and clears outputs
//   mode      0 = direct decode, 1 = auto-scan (scan builds only)
//   in_valid  x is valid
//   in_ready  x is accepted (DIRECT state with en high)
//   x         select value
//   y         registered one-hot output
//   out_valid one-cycle pulse when y updates
//   idx       binary index of the asserted y bit
//   wrap      one-cycle pulse when the scan steps from OUT_W-1 to 0
module reg_decoder_n #(
    parameter  int unsigned SEL_W    = 3,
    parameter  int unsigned SCAN_DIV = 4,
    localparam int unsigned OUT_W    = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] x,
    output logic [OUT_W-1:0] y,
    output logic             out_valid,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1
`ifdef REG_DECODER_SCAN_EN
        ,
        SCAN   = 2'd2
`endif
    } state_t;

    state_t state;

    // rst_n is folded in so in_ready drops the instant reset asserts.
    assign in_ready = rst_n && en && (state == DIRECT);

`ifdef REG_DECODER_SCAN_EN
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(OUT_W - 1);

    logic [DIV_W-1:0] div;
    logic [SEL_W-1:0] idx_nxt;

    assign idx_nxt = idx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            y         <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            div       <= '0;
        end else begin
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            if (!en) begin
                state <= IDLE;
                y     <= '0;
                idx   <= '0;
                div   <= '0;
            end else begin
                unique case (1'b1)
                    (state == IDLE),
                    (state == DIRECT): begin
                        if (mode) begin
                            // Scan always restarts from bit 0.
                            state     <= SCAN;
                            y         <= OUT_W'(1);
                            idx       <= '0;
                            out_valid <= 1'b1;
                            div       <= '0;
                        end else if (state == IDLE) begin
                            state <= DIRECT;
                        end else if (in_valid && in_ready) begin
                            y         <= OUT_W'(1) << x;
                            idx       <= x;
                            out_valid <= 1'b1;
                        end
                    end
                    (state == SCAN): begin
                        if (!mode) begin
                            // y/idx hold until the first accepted transfer.
                            state <= DIRECT;
                            div   <= '0;
                        end else if (div == DIV_MAX) begin
                            div       <= '0;
                            idx       <= idx_nxt;
                            y         <= OUT_W'(1) << idx_nxt;
                            out_valid <= 1'b1;
                            wrap      <= (idx == IDX_MAX);
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        y     <= '0;
                        idx   <= '0;
                        div   <= '0;
                    end
                endcase
            end
        end
    end
`else
    // Without scan support mode and SCAN_DIV have no effect.
    logic unused_cfg;
    assign unused_cfg = mode ^ (SCAN_DIV != 0);
    assign wrap       = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            y         <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (!en) begin
                state <= IDLE;
                y     <= '0;
                idx   <= '0;
            end else begin
                unique case (1'b1)
                    (state == IDLE): begin
                        state <= DIRECT;
                    end
                    (state == DIRECT): begin
                        if (in_valid && in_ready) begin
                            y         <= OUT_W'(1) << x;
                            idx       <= x;
                            out_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        y     <= '0;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_decoder_n.sv
// tb_reg_decoder_n: scoreboard bench for reg_decoder_n.
// Three instances: SEL_W=2, SEL_W=3/SCAN_DIV=4, SEL_W=3/SCAN_DIV=1.
module tb_reg_decoder_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nbad = 0;

    // u2: SEL_W=2, SCAN_DIV=4
    logic       en2, mode2, iv2, ir2, ov2, wrap2;
    logic [1:0] x2, idx2;
    logic [3:0] y2;
    // u3: SEL_W=3, SCAN_DIV=4
    logic       en3, mode3, iv3, ir3, ov3, wrap3;
    logic [2:0] x3, idx3;
    logic [7:0] y3;
    // u1: SEL_W=3, SCAN_DIV=1
    logic       en1, mode1, iv1, ir1, ov1, wrap1;
    logic [2:0] x1, idx1;
    logic [7:0] y1;

    reg_decoder_n #(.SEL_W(2), .SCAN_DIV(4)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2),
        .in_valid(iv2), .in_ready(ir2), .x(x2), .y(y2),
        .out_valid(ov2), .idx(idx2), .wrap(wrap2)
    );
    reg_decoder_n #(.SEL_W(3), .SCAN_DIV(4)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3),
        .in_valid(iv3), .in_ready(ir3), .x(x3), .y(y3),
        .out_valid(ov3), .idx(idx3), .wrap(wrap3)
    );
    reg_decoder_n #(.SEL_W(3), .SCAN_DIV(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1),
        .in_valid(iv1), .in_ready(ir1), .x(x1), .y(y1),
        .out_valid(ov1), .idx(idx1), .wrap(wrap1)
    );

    // Record: cycle, wrap, idx, y.
    function automatic logic [63:0] mk(int c, logic w,
                                       logic [7:0] i, logic [15:0] yv);
        return {32'(c), 7'd0, w, i, yv};
    endfunction

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nbad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic spurious(string nm, logic [63:0] a);
        nvec++;
        nbad++;
        $display("FAIL %s: unexpected output %h", nm, a);
    endtask

    logic [63:0] q2[$];
    logic [63:0] q3[$];
    logic [63:0] q1[$];

    // Monitor: pops the scoreboard whenever an instance pulses out_valid.
    always @(negedge clk) begin
        logic [63:0] a;
        if (ov2) begin
            a = mk(cyc, wrap2, 8'(idx2), 16'(y2));
            if (q2.size() == 0) spurious("u2 out", a);
            else chk("u2 out", a, q2.pop_front());
        end
        if (ov3) begin
            a = mk(cyc, wrap3, 8'(idx3), 16'(y3));
            if (q3.size() == 0) spurious("u3 out", a);
            else chk("u3 out", a, q3.pop_front());
        end
        if (ov1) begin
            a = mk(cyc, wrap1, 8'(idx1), 16'(y1));
            if (q1.size() == 0) spurious("u1 out", a);
            else chk("u1 out", a, q1.pop_front());
        end
        if (wrap2 && !ov2) spurious("u2 wrap", 64'(wrap2));
        if (wrap3 && !ov3) spurious("u3 wrap", 64'(wrap3));
        if (wrap1 && !ov1) spurious("u1 wrap", 64'(wrap1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ey4[4] = '{16'h1, 16'h2, 16'h4, 16'h8};
    logic [15:0] ey8[8] = '{16'h01, 16'h02, 16'h04, 16'h08,
                            16'h10, 16'h20, 16'h40, 16'h80};

    initial begin
        int c;
        rst_n = 1'b0;
        {en2, mode2, iv2, x2} = '0;
        {en3, mode3, iv3, x3} = '0;
        {en1, mode1, iv1, x1} = '0;

        // reset state
        @(negedge clk);
        chk("rst y2", 64'(y2), 64'd0);
        chk("rst y3", 64'(y3), 64'd0);
        chk("rst idx3", 64'(idx3), 64'd0);
        chk("rst ov/ir/wrap3", 64'({ov3, ir3, wrap3}), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // en=0 ignores in_valid
        iv2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x2 = 2'(i);
            @(negedge clk);
            chk("off y2", 64'(y2), 64'd0);
            chk("off ir2", 64'(ir2), 64'd0);
            chk("off ov2", 64'(ov2), 64'd0);
            step();
        end

        // direct decode, SEL_W=2
        iv2 = 1'b0;
        en2 = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            iv2 = 1'b1;
            x2  = 2'(i);
            q2.push_back(mk(cyc + 1, 1'b0, 8'(i), ey4[i]));
            step();
        end
        iv2 = 1'b0;
        step();
        @(negedge clk);
        chk("hold y2", 64'(y2), 64'h8);
        chk("hold idx2", 64'(idx2), 64'd3);
        chk("hold ir2", 64'(ir2), 64'd1);

`ifdef REG_DECODER_SCAN_EN
        // DIRECT -> SCAN restarts at 0; SCAN -> DIRECT holds y
        step();
        mode2 = 1'b1;
        q2.push_back(mk(cyc + 1, 1'b0, 8'd0, 16'h1));
        step();
        mode2 = 1'b0;
        step();
        @(negedge clk);
        chk("back y2", 64'(y2), 64'h1);
        chk("back ir2", 64'(ir2), 64'd1);
        step();
        en2 = 1'b0;
        step();

        // scan, SCAN_DIV=4, 40 cycles
        en3   = 1'b1;
        mode3 = 1'b1;
        c     = cyc;
        for (int k = 0; k < 10; k++)
            q3.push_back(mk(c + 1 + 4 * k, k == 8, 8'(k % 8), ey8[k % 8]));
        repeat (40) @(posedge clk);
        #1;
        en3 = 1'b0;
        step();
        @(negedge clk);
        chk("idle y3", 64'(y3), 64'd0);
        step();

        // scan, SCAN_DIV=1
        en1   = 1'b1;
        mode1 = 1'b1;
        c     = cyc;
        for (int k = 0; k < 17; k++)
            q1.push_back(mk(c + 1 + k, (k == 8) || (k == 16),
                            8'(k % 8), ey8[k % 8]));
        repeat (17) @(posedge clk);
        #1;
        en1 = 1'b0;
        step();

        // reset mid-scan at idx 5
        en3   = 1'b1;
        mode3 = 1'b1;
        c     = cyc;
        for (int k = 0; k < 6; k++)
            q3.push_back(mk(c + 1 + 4 * k, 1'b0, 8'(k), ey8[k]));
        repeat (21) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre-rst idx3", 64'(idx3), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("async y3", 64'(y3), 64'd0);
        chk("async idx3", 64'(idx3), 64'd0);
        chk("async ov3", 64'(ov3), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        q3.push_back(mk(cyc + 1, 1'b0, 8'd0, 16'h01));
        rst_n = 1'b1;
        step();
        en3 = 1'b0;
        step();
`else
        en2 = 1'b0;
        step();

        // no scan support: mode ignored, direct decode only
        en3   = 1'b1;
        mode3 = 1'b1;
        step();
        @(negedge clk);
        chk("ns ir3", 64'(ir3), 64'd1);
        step();
        iv3 = 1'b1;
        x3  = 3'd3;
        q3.push_back(mk(cyc + 1, 1'b0, 8'd3, 16'h08));
        step();
        iv3 = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("ns y3", 64'(y3), 64'h08);
        chk("ns wrap3", 64'(wrap3), 64'd0);
        step();
        en3 = 1'b0;
        step();
`endif

        repeat (3) step();
        chk("q2 drained", 64'(q2.size()), 64'd0);
        chk("q3 drained", 64'(q3.size()), 64'd0);
        chk("q1 drained", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
